// File: rtl/fpu_la_pkg.sv
// LA probe bit map, FSM state encoding and field widths shared by the FPU LA bridge.
package fpu_la_pkg;
  localparam int LA_W    = 128;
  // la_data_in fields
  localparam int A_LSB   = 0;
  localparam int B_LSB   = 32;
  localparam int C_LSB   = 64;
  localparam int OP_LSB  = 96;
  localparam int RM_LSB  = 100;
  localparam int RM_W    = 3;
  localparam int CLR_BIT = 126;
  localparam int TOG_BIT = 127;
  // la_data_out fields
  localparam int RES_LSB  = 0;
  localparam int FLG_LSB  = 32;
  localparam int BUSY_BIT = 37;
  localparam int OVR_BIT  = 38;
  localparam int TO_BIT   = 39;
  localparam int CNT_LSB  = 40;
  localparam int ACK_BIT  = 48;

  localparam int FLAGS_W = 5;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
endpackage

// File: rtl/la_toggle_det.sv
// Command toggle edge detector: primes on the first valid la_q sample, then pulses change for one cycle per toggle edge.
// Zero latency from la_q; no back-pressure (every edge is consumed, gated off while the probe is not driven).
module la_toggle_det (
  input  logic clk,
  input  logic rst_l,
  input  logic la_vld,
  input  logic tog,
  input  logic oenb,
  output logic change
);
  logic primed_q;
  logic tog_seen_q;

  // tog_seen tracks la_q every cycle: a change is either issued, flagged as overrun, or masked by oenb
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      primed_q   <= 1'b0;
      tog_seen_q <= 1'b0;
    end else if (la_vld) begin
      primed_q   <= 1'b1;
      tog_seen_q <= tog;
    end
  end

  assign change = primed_q & ~oenb & (tog ^ tog_seen_q);
endmodule

// File: rtl/fpu_la_bridge.sv
// LA-probe command bridge: one FPU request per toggle, result/flags/status returned on la_data_out.
// req_valid 2 cycles after toggle, held with stable payload under req_ready back-pressure; WAIT aborts after TIMEOUT cycles.
module fpu_la_bridge
  import fpu_la_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [LA_W-1:0]   la_data_in,
  input  logic [LA_W-1:0]   la_oenb,
  output logic [LA_W-1:0]   la_data_out,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [OP_W-1:0]   req_op,
  output logic [RM_W-1:0]   req_rm,
  output logic [DATA_W-1:0] req_a,
  output logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] req_c,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_result,
  input  logic [FLAGS_W-1:0] resp_flags
);
  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [LA_W-1:0]     la_q;
  logic                la_q_vld;
  logic                cmd_chg;
  logic                issue, done_ok, done_to, clr;
  logic [TCNT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   result_q;
  logic [FLAGS_W-1:0]  flags_q;
  logic                overrun_q, timeout_q, ack_q;
  logic [CNT_W-1:0]    cmd_cnt_q;
  logic                unused_la;

  assign unused_la = ^{la_oenb[CLR_BIT-1:0], la_q[CLR_BIT-1:RM_LSB+RM_W]};

  la_toggle_det u_tog (
    .clk    (clk),
    .rst_l  (rst_l),
    .la_vld (la_q_vld),
    .tog    (la_q[TOG_BIT]),
    .oenb   (la_oenb[TOG_BIT]),
    .change (cmd_chg)
  );

  assign clr = la_q[CLR_BIT] & ~la_oenb[CLR_BIT];

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      IDLE: if (cmd_chg) begin
        state_d = ISSUE;
        issue   = 1'b1;
      end
      ISSUE: if (req_ready) state_d = WAIT;
      WAIT: begin
        if (resp_valid) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt == TCNT_LAST) begin
          done_to = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      la_q      <= '0;
      la_q_vld  <= 1'b0;
      req_valid <= 1'b0;
      req_op    <= '0;
      req_rm    <= '0;
      req_a     <= '0;
      req_b     <= '0;
      req_c     <= '0;
      wait_cnt  <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
      cmd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      la_q     <= la_data_in;
      la_q_vld <= 1'b1;
      if (issue) begin
        req_valid <= 1'b1;
        req_a     <= la_q[A_LSB +: DATA_W];
        req_b     <= la_q[B_LSB +: DATA_W];
        req_c     <= la_q[C_LSB +: DATA_W];
        req_op    <= la_q[OP_LSB +: OP_W];
        req_rm    <= la_q[RM_LSB +: RM_W];
        timeout_q <= 1'b0;
      end
      if (state_q == ISSUE && req_ready) req_valid <= 1'b0;
      // counter is zero on the first WAIT cycle
      if (state_q == ISSUE)     wait_cnt <= '0;
      else if (state_q == WAIT) wait_cnt <= wait_cnt + TCNT_W'(1);
      if (done_ok || done_to) begin
        result_q  <= done_ok ? resp_result : '1;
        flags_q   <= done_ok ? resp_flags : '0;
        ack_q     <= ~ack_q;
        cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
      end
      if (done_to) timeout_q <= 1'b1;
      if (cmd_chg && state_q != IDLE) overrun_q <= 1'b1;
      else if (clr)                   overrun_q <= 1'b0;
    end
  end

  always_comb begin
    la_data_out                       = '0;
    la_data_out[RES_LSB +: DATA_W]    = result_q;
    la_data_out[FLG_LSB +: FLAGS_W]   = flags_q;
    la_data_out[BUSY_BIT]             = (state_q != IDLE);
    la_data_out[OVR_BIT]              = overrun_q;
    la_data_out[TO_BIT]               = timeout_q;
    la_data_out[CNT_LSB +: CNT_W]     = cmd_cnt_q;
    la_data_out[ACK_BIT]              = ack_q;
  end
endmodule

// File: tb/tb_fpu_la_bridge.sv
// Directed bench for fpu_la_bridge with a stub FPU driven inline; TIMEOUT reduced to 16.
module tb_fpu_la_bridge;
  logic         clk = 1'b0;
  logic         rst_l;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [2:0]   req_rm;
  logic [31:0]  req_a, req_b, req_c;
  logic         resp_valid;
  logic [31:0]  resp_result;
  logic [4:0]   resp_flags;

  int n_chk  = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  fpu_la_bridge #(.DATA_W(32), .OP_W(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rm      (req_rm),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_c       (req_c),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_flags  (resp_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_l && req_valid && req_ready) hs_cnt <= hs_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flip();
    la_data_in[127] = ~la_data_in[127];
  endtask

  // one full command: toggle, issue, handshake, response on the next cycle
  task automatic do_cmd(input logic [31:0] res);
    flip();
    ticks(3);
    resp_valid  = 1'b1;
    resp_result = res;
    resp_flags  = 5'h00;
    tick();
    resp_valid  = 1'b0;
  endtask

  initial begin
    int hs_base;
    rst_l = 1'b0; la_data_in = '0; la_oenb = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_result = '0; resp_flags = '0;
    ticks(2);
    chk("reset_out", la_data_out, 128'h0);
    chk("reset_req_valid", req_valid, 1'b0);
    rst_l = 1'b1;
    ticks(3);

    // issue and complete
    la_data_in[31:0]  = 32'h3F80_0000;
    la_data_in[63:32] = 32'h4000_0000;
    la_data_in[99:96] = 4'h0;
    req_ready = 1'b1;
    flip();
    tick();
    chk("t1_valid_early", req_valid, 1'b0);
    tick();
    chk("t1_valid", req_valid, 1'b1);
    chk("t1_req_a", req_a, 32'h3F80_0000);
    chk("t1_req_b", req_b, 32'h4000_0000);
    chk("t1_busy", la_data_out[37], 1'b1);
    tick();
    chk("t1_valid_drop", req_valid, 1'b0);
    chk("t1_hs", hs_cnt, 1);
    ticks(2);
    resp_valid = 1'b1; resp_result = 32'h4040_0000; resp_flags = 5'h00;
    tick();
    resp_valid = 1'b0;
    chk("t1_result", la_data_out[31:0], 32'h4040_0000);
    chk("t1_flags", la_data_out[36:32], 5'h00);
    chk("t1_ack", la_data_out[48], 1'b1);
    chk("t1_count", la_data_out[47:40], 8'd1);
    chk("t1_busy_done", la_data_out[37], 1'b0);

    // back-pressure
    req_ready = 1'b0;
    la_data_in[31:0]   = 32'h1111_1111;
    la_data_in[63:32]  = 32'h2222_2222;
    la_data_in[95:64]  = 32'h3333_3333;
    la_data_in[99:96]  = 4'h5;
    la_data_in[102:100] = 3'd2;
    flip();
    ticks(2);
    la_data_in[95:0] = {3{32'hBAD0_BAD0}};
    la_data_in[99:96] = 4'hA;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_held", req_valid, 1'b1);
      chk("t2_a_stable", req_a, 32'h1111_1111);
      chk("t2_b_stable", req_b, 32'h2222_2222);
      chk("t2_c_stable", req_c, 32'h3333_3333);
      chk("t2_op_stable", req_op, 4'h5);
      tick();
    end
    chk("t2_rm", req_rm, 3'd2);
    chk("t2_no_hs_yet", hs_cnt, 1);
    req_ready = 1'b1;
    tick();
    chk("t2_valid_drop", req_valid, 1'b0);
    chk("t2_one_hs", hs_cnt, 2);
    tick();
    resp_valid = 1'b1; resp_result = 32'hC000_0000; resp_flags = 5'h01;
    tick();
    resp_valid = 1'b0;
    chk("t2_result", la_data_out[31:0], 32'hC000_0000);
    chk("t2_flags", la_data_out[36:32], 5'h01);
    chk("t2_count", la_data_out[47:40], 8'd2);
    chk("t2_ack", la_data_out[48], 1'b0);

    // overrun
    flip();
    ticks(3);
    chk("t3_busy", la_data_out[37], 1'b1);
    chk("t3_hs", hs_cnt, 3);
    flip();
    ticks(2);
    chk("t3_overrun", la_data_out[38], 1'b1);
    tick();
    resp_valid = 1'b1; resp_result = 32'h0000_0003; resp_flags = 5'h00;
    tick();
    resp_valid = 1'b0;
    chk("t3_count", la_data_out[47:40], 8'd3);
    chk("t3_ack", la_data_out[48], 1'b1);
    ticks(4);
    chk("t3_no_second_hs", hs_cnt, 3);
    chk("t3_no_second_req", req_valid, 1'b0);
    chk("t3_count_once", la_data_out[47:40], 8'd3);
    chk("t3_overrun_sticky", la_data_out[38], 1'b1);
    la_data_in[126] = 1'b1;
    tick();
    la_data_in[126] = 1'b0;
    chk("t3_overrun_pre_clear", la_data_out[38], 1'b1);
    tick();
    chk("t3_overrun_cleared", la_data_out[38], 1'b0);

    // timeout
    flip();
    ticks(3);
    ticks(15);
    chk("t4_busy_before_to", la_data_out[37], 1'b1);
    chk("t4_to_before", la_data_out[39], 1'b0);
    tick();
    chk("t4_busy_after_to", la_data_out[37], 1'b0);
    chk("t4_result", la_data_out[31:0], 32'hFFFF_FFFF);
    chk("t4_flags", la_data_out[36:32], 5'h00);
    chk("t4_to_bit", la_data_out[39], 1'b1);
    chk("t4_ack", la_data_out[48], 1'b0);
    chk("t4_count", la_data_out[47:40], 8'd4);
    resp_valid = 1'b1; resp_result = 32'h1234_5678; resp_flags = 5'h1F;
    tick();
    resp_valid = 1'b0;
    tick();
    chk("t4_late_result", la_data_out[31:0], 32'hFFFF_FFFF);
    chk("t4_late_count", la_data_out[47:40], 8'd4);
    chk("t4_late_ack", la_data_out[48], 1'b0);
    chk("t4_late_flags", la_data_out[36:32], 5'h00);
    flip();
    ticks(2);
    chk("t4_to_cleared", la_data_out[39], 1'b0);
    chk("t4_reissue", req_valid, 1'b1);
    tick();
    resp_valid = 1'b1; resp_result = 32'hAAAA_5555; resp_flags = 5'h00;
    tick();
    resp_valid = 1'b0;
    chk("t4_count_next", la_data_out[47:40], 8'd5);
    chk("t4_ack_next", la_data_out[48], 1'b1);

    // priming: toggle bit already high when reset releases
    la_data_in[127] = 1'b1;
    #2 rst_l = 1'b0;
    tick();
    chk("t5_reset_out", la_data_out, 128'h0);
    rst_l = 1'b1;
    hs_base = hs_cnt;
    ticks(6);
    chk("t5_prime_no_req", req_valid, 1'b0);
    chk("t5_prime_idle", la_data_out[37], 1'b0);
    chk("t5_prime_no_hs", hs_cnt, hs_base);
    la_oenb[127] = 1'b1;
    flip();
    ticks(4);
    chk("t5_oenb_no_req0", req_valid, 1'b0);
    flip();
    ticks(4);
    la_oenb[127] = 1'b0;
    ticks(4);
    chk("t5_oenb_no_req1", req_valid, 1'b0);
    chk("t5_oenb_idle", la_data_out[37], 1'b0);
    chk("t5_oenb_no_hs", hs_cnt, hs_base);

    // reset while in WAIT
    la_data_in[31:0] = 32'hDEAD_BEEF;
    flip();
    ticks(3);
    chk("t6_in_wait", la_data_out[37], 1'b1);
    chk("t6_req_a_loaded", req_a, 32'hDEAD_BEEF);
    #2 rst_l = 1'b0;
    #1;
    chk("t6_rst_out", la_data_out, 128'h0);
    chk("t6_rst_valid", req_valid, 1'b0);
    chk("t6_rst_req_a", req_a, 32'h0);
    tick();
    rst_l = 1'b1;
    resp_valid = 1'b1; resp_result = 32'h5A5A_5A5A; resp_flags = 5'h1F;
    tick();
    resp_valid = 1'b0;
    tick();
    chk("t6_pending_ignored", la_data_out, 128'h0);
    chk("t6_no_req", req_valid, 1'b0);
    ticks(2);

    // counter wrap
    for (int i = 0; i < 255; i++) do_cmd(32'(i));
    chk("t7_count_255", la_data_out[47:40], 8'hFF);
    chk("t7_ack_255", la_data_out[48], 1'b1);
    do_cmd(32'h0000_BEEF);
    chk("t7_count_wrap", la_data_out[47:40], 8'h00);
    chk("t7_ack_parity", la_data_out[48], 1'b0);
    chk("t7_result", la_data_out[31:0], 32'h0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_la_bridge.md
# fpu_la_bridge

Logic-analyzer command bridge in the user project, directly upstream of the FPU core. Firmware on the management SoC writes operands, opcode and rounding mode onto the LA probes, then flips a command toggle bit. The bridge issues one FPU request per toggle over a valid/ready handshake and captures the result and exception flags. It returns them on the LA input probes for the firmware checkpoint code that drives mprj_io[31:16].

## Interface
- DATA_W, 32: operand/result width
- OP_W, 4: FPU opcode width
- TIMEOUT, 1024: max cycles in WAIT before abort (≥2)
- clk  in  1  user clock (wb_clk_i)
- rst_l  in  1  asynchronous, active-low reset
- la_data_in  in  128  from mgmt SoC; [31:0]=a, [63:32]=b, [95:64]=c, [99:96]=op, [102:100]=rm, [126]=clear sticky, [127]=cmd toggle
- la_oenb  in  128  LA output-enable, active-low; only bits 126/127 are checked
- la_data_out  out  128  to mgmt SoC; [31:0]=result, [36:32]=flags, [37]=busy, [38]=overrun, [39]=timeout, [47:40]=cmd_count, [48]=ack toggle, [127:49]=0
- req_valid  out  1  request to FPU
- req_ready  in  1  FPU accepts request
- req_op  out  OP_W  opcode
- req_rm  out  3  rounding mode
- req_a, req_b, req_c  out  DATA_W  operands
- resp_valid  in  1  one-cycle result strobe from FPU
- resp_result  in  DATA_W  result
- resp_flags  in  5  NV,DZ,OF,UF,NX

## Operation
- la_data_in is registered every cycle into la_q; all decisions use la_q.
- tog_seen tracks the last consumed toggle value. In the first cycle after reset it loads la_q[127] without issuing a command.
- While la_oenb[127]=1, tog_seen follows la_q[127] and no command is issued.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE when la_oenb[127]=0 and la_q[127]≠tog_seen. On that transition:
  - latch a/b/c/op/rm into the req_* registers
  - tog_seen←la_q[127]
  - timeout bit clears
- ISSUE: req_valid=1 with a stable payload. Moves to WAIT at the edge where req_valid&req_ready.
- WAIT: on resp_valid:
  - result/flags are captured into la_data_out
  - ack toggles
  - cmd_count increments, wrapping 255→0
  - state → IDLE
- WAIT timeout: after TIMEOUT cycles without resp_valid:
  - result←32'hFFFF_FFFF, flags←0, timeout←1
  - ack toggles, cmd_count increments
  - state → IDLE
  - a late resp_valid is ignored
- resp_valid in IDLE or ISSUE is ignored.
- Overrun: a toggle change seen in ISSUE/WAIT sets overrun (sticky). That command is consumed (tog_seen updates) but never issued.
- Clear: la_q[126]=1 with la_oenb[126]=0 clears overrun. If a set and a clear occur in the same cycle, set wins.
- busy=1 in ISSUE and WAIT.

## Timing
- Reset values: every output and register is 0, FSM is in IDLE, tog_seen is unprimed.
- Toggle on la_data_in at edge N → la_q at N+1 → req_valid=1 after edge N+2.
- req_valid and the payload are registered outputs. They deassert in the cycle after the handshake edge.
- resp_valid at edge M → la_data_out updated and busy=0 after edge M. This is the earliest point a new toggle can issue.
- The timeout counter starts at 0 on entry to WAIT and aborts at count TIMEOUT−1.
- If rst_l asserts mid-operation, everything resets immediately. A pending FPU response after reset is ignored because the FSM is in IDLE.

## Structure
- Package fpu_la_pkg holds:
  - LA bit-position constants (A_LSB, B_LSB, C_LSB, OP_LSB, RM_LSB, CLR_BIT, TOG_BIT, and all output field positions)
  - the state enum {IDLE, ISSUE, WAIT}
  - the flags width
- One sub-module, la_toggle_det, contains the priming logic, tog_seen, oenb gating and the change pulse.
- FSM, timeout counter and output register live in the top module.

## Test plan
- Issue and complete:
  - Stimulus: a=32'h3F80_0000, b=32'h4000_0000, op=0, toggle 0→1; stub FPU holds req_ready=1 and answers 3 cycles later with 32'h4040_0000, flags=0.
  - Response: req_valid 2 cycles after the toggle; out[31:0]=32'h4040_0000, ack=1, cmd_count=1, busy=0.
- Back-pressure:
  - Stimulus: req_ready held low for 5 cycles.
  - Response: req_valid stays high and req_a/b/c/op are stable all 5 cycles; exactly one handshake occurs.
- Overrun:
  - Stimulus: toggle again while in WAIT.
  - Response: overrun=1, no second request, cmd_count increments by 1 only.
  - Stimulus: then set bit 126 for one cycle.
  - Response: overrun=0.
- Timeout:
  - Stimulus: TIMEOUT=16 and the stub never responds.
  - Response: after 16 WAIT cycles, result=32'hFFFF_FFFF, timeout=1, ack toggles; a later resp_valid changes nothing.
- Reset/priming:
  - Stimulus: la_data_in[127]=1 at reset release.
  - Response: no request issued.
  - Stimulus: la_oenb[127]=1 while toggling.
  - Response: no request issued.
  - Stimulus: reset asserted in WAIT.
  - Response: all outputs 0.
- Wrap:
  - Stimulus: 256 completed commands.
  - Response: cmd_count returns to 0 and ack toggle parity is 0.
